// File: rtl/alu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pkg : state encoding and slice select codes for the sequencer
// Rev 1.0
// ------------------------------------------------------------------
package alu_pkg;
    localparam int NIBBLE_W = 4;

    localparam logic [3:0] SEL_ADD = 4'b1001;
    localparam logic [3:0] SEL_AND = 4'b1011;
    localparam logic [3:0] SEL_XOR = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/alu_seq_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_seq_fsm : IDLE/RUN/DONE control, nibble counter and handshakes
// Rev 1.0
// ------------------------------------------------------------------
module alu_seq_fsm
    import alu_pkg::*;
#(
    parameter int NIB = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    input  logic                   out_ready_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    output logic                   accept_o,
    output logic                   run_o,
    output logic                   last_o,
    output logic [$clog2(NIB)-1:0] cnt_o
);
    localparam int               CNT_W  = $clog2(NIB);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NIB - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    assign accept_o    = (state_q == IDLE) && in_valid_i && !flush_i;
    assign run_o       = (state_q == RUN);
    assign last_o      = run_o && (cnt_q == C_LAST);
    assign cnt_o       = cnt_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;

    // flush shares the reset values but is sampled synchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_q == C_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_nibble_sequencer : runs a WIDTH-bit op through a 4-bit ALU slice,
// one nibble per clock, LSB first. Define ALU_SEQ_FLAGS_EN for zero/neg flags.
// Rev 1.0
// ------------------------------------------------------------------
module alu_nibble_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_s,
    input  logic             in_m,
    input  logic             in_cin,
    output logic [3:0]       slc_a,
    output logic [3:0]       slc_b,
    output logic [3:0]       slc_s,
    output logic             slc_m,
    output logic             slc_cin,
    input  logic [3:0]       slc_f,
    input  logic             slc_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB);
    localparam int IDX_W = CNT_W + 2;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt;
    logic [IDX_W-1:0] w_base;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q;

    alu_seq_fsm #(
        .NIB (NIB)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .accept_o    (w_accept),
        .run_o       (w_run),
        .last_o      (w_last),
        .cnt_o       (w_cnt)
    );

    assign w_base = {w_cnt, 2'b00};

    assign slc_a   = w_run ? a_q[w_base +: NIBBLE_W] : '0;
    assign slc_b   = w_run ? b_q[w_base +: NIBBLE_W] : '0;
    assign slc_s   = s_q;
    assign slc_m   = m_q;
    assign slc_cin = carry_q;

    assign out_f    = res_q;
    assign out_cout = cout_q;

    // carry ripples in logic mode too; the slice decides whether to use it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else if (flush) begin
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else if (w_accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            s_q     <= in_s;
            m_q     <= in_m;
            carry_q <= in_cin;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else if (w_run) begin
            res_q[w_base +: NIBBLE_W] <= slc_f;
            carry_q                   <= slc_cout;
            if (w_last) begin
                cout_q <= slc_cout;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic [WIDTH-1:0] w_res_fin;
    logic             zero_q;
    logic             neg_q;

    // final result as it will look after the last nibble is written
    always_comb begin
        w_res_fin                     = res_q;
        w_res_fin[w_base +: NIBBLE_W] = slc_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (flush || w_accept) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (w_last) begin
            zero_q <= (w_res_fin == '0);
            neg_q  <= w_res_fin[WIDTH-1];
        end
    end

    assign out_zero = zero_q;
    assign out_neg  = neg_q;
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_nibble_sequencer : vector table, random ops vs word-level model,
// plus backpressure, flush and async-reset sequences.
// Rev 1.0
// ------------------------------------------------------------------
module tb_alu_nibble_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_a      = '0;
    logic [WIDTH-1:0] in_b      = '0;
    logic [3:0]       in_s      = '0;
    logic             in_m      = 1'b0;
    logic             in_cin    = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [3:0]       slc_a, slc_b, slc_s, slc_f;
    logic             slc_m, slc_cin, slc_cout;
    logic             out_valid, out_cout, out_zero, out_neg;
    logic [WIDTH-1:0] out_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_s      (in_s),
        .in_m      (in_m),
        .in_cin    (in_cin),
        .slc_a     (slc_a),
        .slc_b     (slc_b),
        .slc_s     (slc_s),
        .slc_m     (slc_m),
        .slc_cin   (slc_cin),
        .slc_f     (slc_f),
        .slc_cout  (slc_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    // 4-bit slice: logic-mode carry out is cin XOR parity(f) so the ripple is observable
    always_comb begin
        slc_f    = 4'h0;
        slc_cout = 1'b0;
        if (slc_m) begin
            case (slc_s)
                SEL_AND: slc_f = slc_a & slc_b;
                SEL_XOR: slc_f = slc_a ^ slc_b;
                default: slc_f = slc_a | slc_b;
            endcase
            slc_cout = slc_cin ^ (^slc_f);
        end else if (slc_s == SEL_ADD) begin
            {slc_cout, slc_f} = {1'b0, slc_a} + {1'b0, slc_b} + {4'b0, slc_cin};
        end else begin
            {slc_cout, slc_f} = {1'b0, slc_a} + {1'b0, ~slc_b} + {4'b0, slc_cin};
        end
    end

    // whole-word reference: {cout, f}
    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [3:0] s, input logic m, input logic cin);
        logic [WIDTH-1:0] f;
        logic             c;
        if (m) begin
            case (s)
                SEL_AND: f = a & b;
                SEL_XOR: f = a ^ b;
                default: f = a | b;
            endcase
            c = cin ^ (^f);
        end else if (s == SEL_ADD) begin
            {c, f} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        end else begin
            {c, f} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(cin);
        end
        return {c, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] s,
                         input logic m, input logic cin, input int hold,
                         output logic [WIDTH-1:0] f, output logic c, output logic z,
                         output logic n, output int lat);
        int w;
        @(negedge clk);
        in_a = a; in_b = b; in_s = s; in_m = m; in_cin = cin; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        f = out_f; c = out_cout; z = out_zero; n = out_neg;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       s;
        logic             m;
        logic             cin;
        logic [WIDTH-1:0] f;
        logic             cout;
        logic             zero;
        logic             neg;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [WIDTH-1:0] f;
        logic             c, z, n, seen;
        logic [WIDTH:0]   r;
        logic [3:0]       s;
        logic             m, cin;
        logic [WIDTH-1:0] a, b;
        int               lat, cyc;

        vecs[0] = '{16'h1234, 16'h0FFF, SEL_ADD, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, SEL_ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'hF0F0, 16'h3C3C, SEL_AND, 1'b1, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'hA5A5, 16'h0FF0, SEL_XOR, 1'b1, 1'b1, 16'hAA55, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0003, 4'b0000, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0000, SEL_ADD, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

        // reset values while rst_n is held low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_f", out_f, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_neg", out_neg, 0);
        chk("rst_slc_a", slc_a, 0);
        chk("rst_slc_b", slc_b, 0);
        chk("rst_slc_s", slc_s, 0);
        chk("rst_slc_m", slc_m, 0);
        chk("rst_slc_cin", slc_cin, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin, i % 3, f, c, z, n, lat);
            chk($sformatf("vec%0d_f", i), f, vecs[i].f);
            chk($sformatf("vec%0d_cout", i), c, vecs[i].cout);
            chk($sformatf("vec%0d_zero", i), z, vecs[i].zero & FLAGS_ON);
            chk($sformatf("vec%0d_neg", i), n, vecs[i].neg & FLAGS_ON);
            chk($sformatf("vec%0d_latency", i), lat, NIB + 1);
            chk($sformatf("vec%0d_release", i), {in_ready, out_valid}, 2'b10);
        end

        for (int k = 0; k < 40; k++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            m   = 1'($urandom);
            cin = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       s = SEL_ADD;
                1:       s = SEL_AND;
                2:       s = SEL_XOR;
                default: s = 4'($urandom);
            endcase
            if (k % 8 == 0) b = ~a;
            r = ref_op(a, b, s, m, cin);
            do_op(a, b, s, m, cin, $urandom_range(0, 3), f, c, z, n, lat);
            chk("rand_f", f, r[WIDTH-1:0]);
            chk("rand_cout", c, r[WIDTH]);
            chk("rand_zero", z, FLAGS_ON & (r[WIDTH-1:0] == '0));
            chk("rand_neg", n, FLAGS_ON & r[WIDTH-1]);
            chk("rand_latency", lat, NIB + 1);
        end

        // backpressure: result held, new requests ignored
        @(negedge clk);
        in_a = 16'h1234; in_b = 16'h0FFF; in_s = SEL_ADD; in_m = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 16'hDEAD; in_b = 16'hBEEF;
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            chk("bp_run_in_ready", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_f", out_f, 16'h2233);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);

        // flush at nibble 2, racing in_valid and out_ready
        @(negedge clk);
        in_a = 16'hABCD; in_b = 16'h1111; in_s = SEL_ADD; in_m = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("flush_slc_a_nib2", slc_a, 4'hB);
        chk("flush_slc_b_nib2", slc_b, 4'h1);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", seen, 0);
        do_op(16'h1234, 16'h0FFF, SEL_ADD, 1'b0, 1'b0, 0, f, c, z, n, lat);
        chk("flush_next_f", f, 16'h2233);
        chk("flush_next_cout", c, 0);

        // asynchronous reset between clock edges mid-RUN
        @(negedge clk);
        in_a = 16'hFFFF; in_b = 16'h0001; in_s = SEL_ADD; in_m = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_f", out_f, 0);
        chk("arst_out_cout", out_cout, 0);
        chk("arst_slc_a", slc_a, 0);
        chk("arst_slc_b", slc_b, 0);
        chk("arst_slc_s", slc_s, 0);
        chk("arst_slc_m", slc_m, 0);
        chk("arst_slc_cin", slc_cin, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h1234, 16'h0FFF, SEL_ADD, 1'b0, 1'b0, 0, f, c, z, n, lat);
        chk("arst_next_f", f, 16'h2233);
        chk("arst_next_cout", c, 0);
        chk("arst_next_latency", lat, NIB + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule
`default_nettype wire
